// File: rtl/pipearch_reorder.sv
// In-order reassembly of out-of-order CCI-P read responses through a BRAM ring.
// Optional protocol checking is built only when PIPEARCH_REORDER_CHECK_EN is defined.
module pipearch_reorder #(
  parameter int LOG2_DEPTH = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         op_start,
  input  logic [31:0]  num_lines,
  input  logic         rsp_valid,
  input  logic [15:0]  rsp_mdata,
  input  logic [1:0]   rsp_cl_num,
  input  logic [511:0] rsp_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_data,
  output logic [31:0]  out_index,
  output logic [31:0]  window_base,
  output logic         op_done,
  output logic         err
);

  localparam int DEPTH = 1 << LOG2_DEPTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state, state_next;
  logic [31:0]             num_lines_q;
  logic [31:0]             rd_ptr;
  logic [31:0]             wb;
  logic [DEPTH-1:0]        slot_valid;
  logic [511:0]            mem      [DEPTH];
  logic [31:0]             line_mem [DEPTH];
  logic [511:0]            rd_data;
  logic [31:0]             rd_line;
  logic                    rd_inflight;
  logic [511:0]            fifo_data [2];
  logic [31:0]             fifo_line [2];
  logic                    fifo_head, fifo_tail;
  logic [1:0]              fifo_count;

  logic [15:0]             rsp_idx;
  logic [LOG2_DEPTH-1:0]   wr_slot, rd_slot;
  logic [31:0]             rsp_line;
  logic                    wr_en, pop, issue, start;
  logic [2:0]              occupancy;

  assign rsp_idx   = rsp_mdata + {14'b0, rsp_cl_num};
  assign wr_slot   = rsp_idx[LOG2_DEPTH-1:0];
  assign rd_slot   = rd_ptr[LOG2_DEPTH-1:0];
  // Responses are always within DEPTH of the release point, so the 16-bit
  // index can be widened by its distance from window_base.
  assign rsp_line  = wb + {16'b0, rsp_idx - wb[15:0]};
  assign wr_en     = (state == RUN) && rsp_valid;
  assign start     = (state == IDLE) && op_start;
  assign pop       = (fifo_count != 2'd0) && out_ready;
  assign occupancy = {1'b0, fifo_count} + {2'b0, rd_inflight} - {2'b0, pop};
  assign issue     = (state == RUN) && slot_valid[rd_slot] &&
                     (rd_ptr < num_lines_q) && (occupancy < 3'd2);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (op_start) state_next = RUN;
      RUN:  if ((wb == num_lines_q) || (pop && (wb + 32'd1 == num_lines_q)))
              state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      num_lines_q <= '0;
      rd_ptr      <= '0;
      wb          <= '0;
      slot_valid  <= '0;
      rd_inflight <= 1'b0;
      fifo_head   <= 1'b0;
      fifo_tail   <= 1'b0;
      fifo_count  <= '0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_line[i] <= '0;
      end
    end else begin
      state       <= state_next;
      rd_inflight <= issue;
      if (start) begin
        num_lines_q <= num_lines;
        rd_ptr      <= '0;
        wb          <= '0;
        slot_valid  <= '0;
        fifo_head   <= 1'b0;
        fifo_tail   <= 1'b0;
        fifo_count  <= '0;
      end else begin
        if (issue) begin
          slot_valid[rd_slot] <= 1'b0;
          rd_ptr              <= rd_ptr + 32'd1;
        end
        if (wr_en)
          slot_valid[wr_slot] <= 1'b1;
        if (pop) begin
          wb        <= wb + 32'd1;
          fifo_head <= ~fifo_head;
        end
        if (rd_inflight) begin
          fifo_data[fifo_tail] <= rd_data;
          fifo_line[fifo_tail] <= rd_line;
          fifo_tail            <= ~fifo_tail;
        end
        fifo_count <= fifo_count + {1'b0, rd_inflight} - {1'b0, pop};
      end
    end
  end

  // Ring storage is left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_slot]      <= rsp_data;
      line_mem[wr_slot] <= rsp_line;
    end
    if (issue) begin
      rd_data <= mem[rd_slot];
      rd_line <= line_mem[rd_slot];
    end
  end

  assign out_valid   = (fifo_count != 2'd0);
  assign out_data    = fifo_data[fifo_head];
  assign out_index   = fifo_line[fifo_head];
  assign window_base = wb;
  assign op_done     = (state == DONE);

`ifdef PIPEARCH_REORDER_CHECK_EN
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  logic        err_q;
  logic [16:0] dist;
  logic        bad;

  assign dist = {1'b0, rsp_idx - wb[15:0]};
  assign bad  = wr_en && (slot_valid[wr_slot] || (dist >= DEPTH_W));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_q <= 1'b0;
    else if (start)
      err_q <= 1'b0;
    else if (bad)
      err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pipearch_reorder.sv
// Scoreboard bench for pipearch_reorder: expected lines are queued in index order
// when an operation is set up, and a negedge monitor checks every handshake.
module tb_pipearch_reorder;

  localparam int LOG2_DEPTH = 6;
  localparam int DEPTH      = 1 << LOG2_DEPTH;
  localparam int MAXN       = 1024;

  logic         clk = 1'b0;
  logic         reset;
  logic         op_start;
  logic [31:0]  num_lines;
  logic         rsp_valid;
  logic [15:0]  rsp_mdata;
  logic [1:0]   rsp_cl_num;
  logic [511:0] rsp_data;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_data;
  logic [31:0]  out_index;
  logic [31:0]  window_base;
  logic         op_done;
  logic         err;

  pipearch_reorder #(.LOG2_DEPTH(LOG2_DEPTH)) dut (
    .clk(clk), .reset(reset), .op_start(op_start), .num_lines(num_lines),
    .rsp_valid(rsp_valid), .rsp_mdata(rsp_mdata), .rsp_cl_num(rsp_cl_num),
    .rsp_data(rsp_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .window_base(window_base),
    .op_done(op_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  idx;
    logic [511:0] data;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  logic [511:0] line_data [MAXN];
  bit           sent      [MAXN];
  int           ord_idx[$];
  int           ord_cl[$];

  int checks = 0, errors = 0;
  int cyc = 0;
  int accepted = 0;
  int done_pulses = 0;
  int first_valid_cyc = 0, last_valid_cyc = 0, first_drive_cyc = 0;
  bit mon_seen = 0;
  int ready_mode = 0;
  bit           held = 0;
  logic [511:0] held_data;
  logic [31:0]  held_index;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkData(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Consumer side: out_ready pattern selected by ready_mode.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: handshake scoreboard plus hold-stability of a stalled line.
  always @(negedge clk) begin
    if (reset) begin
      held = 0;
    end else begin
      if (op_done) done_pulses++;
      if (held) begin
        checkOutput("hold_valid", 64'(out_valid), 64'd1);
        if (out_valid) begin
          checkOutput("hold_index", 64'(out_index), 64'(held_index));
          checkData("hold_data", out_data, held_data);
        end
      end
      held = 0;
      if (out_valid) begin
        if (!mon_seen) begin
          first_valid_cyc = cyc;
          mon_seen = 1;
        end
        last_valid_cyc = cyc;
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL spurious_output: got index %0d, expected no output", out_index);
          end else begin
            mon_e = exp_q.pop_front();
            checkOutput("out_index", 64'(out_index), 64'(mon_e.idx));
            checkData("out_data", out_data, mon_e.data);
            if (out_index < MAXN)
              checkOutput("released_before_written", 64'(sent[out_index]), 64'd1);
            accepted++;
          end
        end else begin
          held       = 1;
          held_index = out_index;
          held_data  = out_data;
        end
      end
    end
  end

  task automatic prepare_op(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      line_data[i] = rand_line();
      sent[i]      = 0;
      exp_q.push_back('{32'(i), line_data[i]});
    end
    accepted = 0;
    mon_seen = 0;
  endtask

  task automatic start_op(input int n, output int start_cyc);
    @(posedge clk); #1;
    op_start  = 1'b1;
    num_lines = 32'(n);
    @(posedge clk); #1;
    op_start  = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic applyStimulus(input int idx, input int cl);
    @(posedge clk); #1;
    rsp_valid  = 1'b1;
    rsp_mdata  = 16'(idx - cl);
    rsp_cl_num = 2'(cl);
    rsp_data   = line_data[idx];
    sent[idx]  = 1;
  endtask

  task automatic idle_rsp();
    @(posedge clk); #1;
    rsp_valid = 1'b0;
  endtask

  task automatic send_order();
    foreach (ord_idx[k]) begin
      applyStimulus(ord_idx[k], ord_cl[k]);
      if (k == 0) first_drive_cyc = cyc;
    end
    idle_rsp();
    ord_idx.delete();
    ord_cl.delete();
  endtask

  task automatic wait_done(input int n, input int start_cyc, input bit check_time);
    bit got = 0;
    int d0 = done_pulses;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (op_done) begin
        got = 1;
        break;
      end
    end
    checkOutput("op_done_seen", 64'(got), 64'd1);
    if (got) begin
      checkOutput("done_out_valid", 64'(out_valid), 64'd0);
      checkOutput("done_window_base", 64'(window_base), 64'(n));
      checkOutput("done_queue_empty", 64'(exp_q.size()), 64'd0);
      if (check_time) checkOutput("zero_len_done_cycle", 64'(cyc - start_cyc), 64'd1);
    end
    repeat (3) @(negedge clk);
    checkOutput("op_done_once", 64'(done_pulses - d0), 64'd1);
`ifndef PIPEARCH_REORDER_CHECK_EN
    checkOutput("err_tied_low", 64'(err), 64'd0);
`endif
  endtask

  task automatic run_random(input int n);
    int pend[$];
    int elig[$];
    int sc;
    for (int i = 0; i < n; i++) pend.push_back(i);
    for (int t = 0; t < 20000 && pend.size() > 0; t++) begin
      elig.delete();
      foreach (pend[j]) if (pend[j] < accepted + DEPTH) elig.push_back(j);
      if (elig.size() == 0 || $urandom_range(0, 3) == 0) begin
        idle_rsp();
      end else begin
        int j = elig[$urandom_range(0, elig.size() - 1)];
        int idx = pend[j];
        pend.delete(j);
        applyStimulus(idx, $urandom_range(0, idx < 3 ? idx : 3));
      end
    end
    idle_rsp();
    checkOutput("random_all_sent", 64'(pend.size()), 64'd0);
    sc = 0;
  endtask

  initial begin
    int sc;
    int mx_idx[8] = '{7, 4, 1, 0, 6, 3, 2, 5};
    int mx_cl[8]  = '{3, 0, 1, 0, 2, 3, 2, 1};
    bit got;

    reset = 1'b1; op_start = 1'b0; num_lines = '0;
    rsp_valid = 1'b0; rsp_mdata = '0; rsp_cl_num = '0; rsp_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_op_done", 64'(op_done), 64'd0);
    checkOutput("reset_window_base", 64'(window_base), 64'd0);
    checkOutput("reset_out_index", 64'(out_index), 64'd0);
    checkData("reset_out_data", out_data, '0);
    checkOutput("reset_err", 64'(err), 64'd0);
    reset = 1'b0;

    // In order, back to back: first output two edges after the first write.
    $display("[TB] in-order");
    ready_mode = 0;
    prepare_op(8);
    start_op(8, sc);
    for (int i = 0; i < 8; i++) begin ord_idx.push_back(i); ord_cl.push_back(0); end
    send_order();
    wait_done(8, sc, 0);
    checkOutput("inorder_latency", 64'(first_valid_cyc - first_drive_cyc), 64'd3);
    checkOutput("inorder_consecutive", 64'(last_valid_cyc - first_valid_cyc), 64'd7);

    $display("[TB] reversed");
    prepare_op(16);
    start_op(16, sc);
    for (int i = 15; i >= 0; i--) begin ord_idx.push_back(i); ord_cl.push_back(0); end
    send_order();
    wait_done(16, sc, 0);

    $display("[TB] multi-line");
    prepare_op(8);
    start_op(8, sc);
    for (int i = 0; i < 8; i++) begin ord_idx.push_back(mx_idx[i]); ord_cl.push_back(mx_cl[i]); end
    send_order();
    wait_done(8, sc, 0);

    $display("[TB] backpressure");
    ready_mode = 1;
    prepare_op(32);
    start_op(32, sc);
    for (int i = 0; i < 32; i++) begin ord_idx.push_back(i); ord_cl.push_back(0); end
    send_order();
    wait_done(32, sc, 0);

    $display("[TB] random window");
    ready_mode = 2;
    prepare_op(300);
    start_op(300, sc);
    run_random(300);
    wait_done(300, sc, 0);
    ready_mode = 0;

    $display("[TB] zero length");
    prepare_op(0);
    start_op(0, sc);
    wait_done(0, sc, 1);

`ifdef PIPEARCH_REORDER_CHECK_EN
    $display("[TB] duplicate write");
    prepare_op(8);
    start_op(8, sc);
    ord_idx = '{3, 3, 0, 1, 2, 4, 5, 6, 7};
    ord_cl  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    send_order();
    checkOutput("err_on_duplicate", 64'(err), 64'd1);
    wait_done(8, sc, 0);
    checkOutput("err_sticky", 64'(err), 64'd1);
`endif

    // Reset in the middle of a stalled-then-draining operation.
    $display("[TB] reset mid-op");
    ready_mode = 3;
    prepare_op(10);
    start_op(10, sc);
    for (int i = 0; i < 10; i++) begin ord_idx.push_back(i); ord_cl.push_back(0); end
    send_order();
    ready_mode = 0;
    got = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (accepted >= 5) begin got = 1; break; end
    end
    checkOutput("reset_midop_progress", 64'(got), 64'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midreset_op_done", 64'(op_done), 64'd0);
    checkOutput("midreset_window_base", 64'(window_base), 64'd0);
    checkOutput("midreset_out_index", 64'(out_index), 64'd0);
    checkData("midreset_out_data", out_data, '0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      line_data[i] = rand_line();
      applyStimulus(i, 0);
    end
    idle_rsp();
    repeat (2) @(negedge clk);
    checkOutput("idle_rsp_ignored", 64'(out_valid), 64'd0);

    prepare_op(4);
    start_op(4, sc);
    ord_idx = '{2, 0, 3, 1};
    ord_cl  = '{0, 0, 0, 0};
    send_order();
    wait_done(4, sc, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

endmodule
